// File: rtl/vector_operand_loader_if.sv
// Handshake bundle between the element producer, the operand loader and the
// dot-product stage. The loader sits on the slave side and the bench or
// upstream logic on the master side.
interface vector_operand_loader_if #(
    parameter int VLEN = 1
);
    localparam int LW = $clog2(VLEN + 1);

    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [32*VLEN-1:0]   out_a;
    logic [32*VLEN-1:0]   out_b;
    logic [LW-1:0]        out_len;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_a, in_b, in_last, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_len, out_valid
    );

    modport slave (
        input  in_a, in_b, in_last, in_valid, out_ready,
        output in_ready, out_a, out_b, out_len, out_valid
    );
endinterface

// File: rtl/vector_operand_loader.sv
// Serial-to-parallel operand collector for the floating-point dot-product stage.
// Packs up to VLEN (a, b) float pairs into two flat vectors, element i at
// bits [32*i +: 32], and holds them until the downstream stage accepts.
// Unused slots of a short vector read as +0.0 so they add nothing to the dot product.
module vector_operand_loader #(
    parameter int VLEN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    vector_operand_loader_if.slave   bus
);
    localparam int W  = 32 * VLEN;
    localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int LW = $clog2(VLEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(VLEN - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [LW-1:0]   len_q, len_d;

    logic            accept_in;
    logic            accept_out;
    logic            complete;

    assign accept_in  = (state_q == FILL) & bus.in_valid;
    assign accept_out = (state_q == FULL) & bus.out_ready;
    assign complete   = accept_in & ((idx_q == LAST_IDX) | bus.in_last);

    // Next-state logic: flush wins over everything, then element capture in FILL,
    // then release of the held vector in FULL (which also clears the buffer).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        len_d   = len_q;

        if (flush_i) begin
            state_d = FILL;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
            len_d   = '0;
        end else if (accept_in) begin
            for (int i = 0; i < VLEN; i++) begin
                if (idx_q == IW'(i)) begin
                    a_d[32*i +: 32] = bus.in_a;
                    b_d[32*i +: 32] = bus.in_b;
                end
            end
            if (complete) begin
                len_d   = LW'(idx_q) + LW'(1);
                idx_d   = '0;
                state_d = FULL;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end else if (accept_out) begin
            a_d     = '0;
            b_d     = '0;
            len_d   = '0;
            state_d = FILL;
        end
    end

    // State and buffer registers, cleared asynchronously so outputs drop to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            len_q   <= len_d;
        end
    end

    assign bus.in_ready  = (state_q == FILL) & ~rst;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_len   = len_q;
endmodule

// File: tb/tb_vector_operand_loader.sv
// Randomized and directed bench for vector_operand_loader (VLEN=4 and VLEN=1 copies).
// Expected values come from a queue-based model of the packing rules.
module tb_vector_operand_loader;
    logic clk = 1'b0;
    logic rst;
    logic flush4;
    logic flush1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vector_operand_loader_if #(.VLEN(4)) bus4 ();
    vector_operand_loader_if #(.VLEN(1)) bus1 ();

    vector_operand_loader #(.VLEN(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush4),
        .bus     (bus4.slave)
    );

    vector_operand_loader #(.VLEN(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush1),
        .bus     (bus1.slave)
    );

    // Reference model for the VLEN=4 instance: pending elements and the held vector.
    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] mA[4];
    logic [31:0] mB[4];
    bit          mFull;
    int          mLen;

    // Reference model for the VLEN=1 instance.
    bit          m1Full;
    logic [31:0] m1A;
    logic [31:0] m1B;
    int          validSeen;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        qA.delete();
        qB.delete();
        for (int i = 0; i < 4; i++) begin
            mA[i] = '0;
            mB[i] = '0;
        end
        mFull  = 0;
        mLen   = 0;
        m1Full = 0;
        m1A    = '0;
        m1B    = '0;
    endtask

    task automatic checkAll4();
        logic [127:0] ea;
        logic [127:0] eb;
        ea = '0;
        eb = '0;
        if (mFull) begin
            for (int i = 0; i < 4; i++) begin
                ea[32*i +: 32] = mA[i];
                eb[32*i +: 32] = mB[i];
            end
        end else begin
            for (int i = 0; i < qA.size(); i++) begin
                ea[32*i +: 32] = qA[i];
                eb[32*i +: 32] = qB[i];
            end
        end
        checkOutput("in_ready",  128'(bus4.in_ready),  128'(!mFull && !rst));
        checkOutput("out_valid", 128'(bus4.out_valid), 128'(mFull));
        checkOutput("out_len",   128'(bus4.out_len),   128'(mLen));
        checkOutput("out_a",     bus4.out_a,           ea);
        checkOutput("out_b",     bus4.out_b,           eb);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic l, input logic r, input logic f);
        bus4.in_valid  = v;
        bus4.in_a      = a;
        bus4.in_b      = b;
        bus4.in_last   = l;
        bus4.out_ready = r;
        flush4         = f;
    endtask

    // Effect of the coming rising edge on the VLEN=4 model.
    task automatic model4();
        if (flush4) begin
            modelReset();
        end else if (!mFull) begin
            if (bus4.in_valid) begin
                qA.push_back(bus4.in_a);
                qB.push_back(bus4.in_b);
                if (qA.size() == 4 || bus4.in_last) begin
                    for (int i = 0; i < 4; i++) begin
                        mA[i] = (i < qA.size()) ? qA[i] : 32'h0;
                        mB[i] = (i < qB.size()) ? qB[i] : 32'h0;
                    end
                    mLen  = qA.size();
                    mFull = 1;
                    qA.delete();
                    qB.delete();
                end
            end
        end else if (bus4.out_ready) begin
            for (int i = 0; i < 4; i++) begin
                mA[i] = '0;
                mB[i] = '0;
            end
            mLen  = 0;
            mFull = 0;
        end
    endtask

    task automatic cycle4(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic l, input logic r, input logic f);
        @(negedge clk);
        checkAll4();
        applyStimulus(v, a, b, l, r, f);
        model4();
    endtask

    task automatic cycle1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
        @(negedge clk);
        checkOutput("v1_in_ready",  128'(bus1.in_ready),  128'(!m1Full));
        checkOutput("v1_out_valid", 128'(bus1.out_valid), 128'(m1Full));
        checkOutput("v1_out_len",   128'(bus1.out_len),   128'(m1Full ? 1 : 0));
        checkOutput("v1_out_a",     128'(bus1.out_a),     128'(m1Full ? m1A : 32'h0));
        checkOutput("v1_out_b",     128'(bus1.out_b),     128'(m1Full ? m1B : 32'h0));
        if (bus1.out_valid) validSeen++;
        bus1.in_valid  = v;
        bus1.in_a      = a;
        bus1.in_b      = b;
        bus1.in_last   = 1'b0;
        bus1.out_ready = r;
        if (!m1Full) begin
            if (v) begin
                m1Full = 1;
                m1A    = a;
                m1B    = b;
            end
        end else if (r) begin
            m1Full = 0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        flush1 = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_last   = 1'b0;
        bus1.out_ready = 1'b0;
        modelReset();
        validSeen = 0;
        #22;
        checkOutput("rst_in_ready", 128'(bus4.in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Async reset in the middle of filling a vector.
        cycle4(1, 32'h11111111, 32'hAAAAAAAA, 0, 0, 0);
        cycle4(1, 32'h22222222, 32'hBBBBBBBB, 0, 0, 0);
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("arst_out_a",     bus4.out_a,            128'h0);
        checkOutput("arst_out_valid", 128'(bus4.out_valid),  128'(0));
        checkOutput("arst_in_ready",  128'(bus4.in_ready),   128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready",   128'(bus4.in_ready),   128'(1));

        // Four-element vector 1.0..4.0 against all-ones.
        cycle4(1, 32'h3F800000, 32'h3F800000, 0, 1, 0);
        cycle4(1, 32'h40000000, 32'h3F800000, 0, 1, 0);
        cycle4(1, 32'h40400000, 32'h3F800000, 0, 1, 0);
        cycle4(1, 32'h40800000, 32'h3F800000, 0, 0, 0);
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);
        checkOutput("t2_out_a", bus4.out_a, 128'h40800000_40400000_40000000_3F800000);
        cycle4(0, 32'h0, 32'h0, 0, 1, 0);

        // Short vector terminated by in_last, then a one-element vector.
        cycle4(1, 32'h7FC00001, 32'h00000001, 0, 0, 0);
        cycle4(1, 32'hFF800000, 32'h80000000, 1, 0, 0);
        cycle4(0, 32'h0, 32'h0, 0, 1, 0);
        cycle4(1, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);
        cycle4(0, 32'h0, 32'h0, 0, 1, 0);

        // Hold the full vector with out_ready low while the producer keeps offering data.
        for (int i = 0; i < 4; i++) cycle4(1, $urandom, $urandom, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle4(1, $urandom, $urandom, 0, 0, 0);
        cycle4(1, $urandom, $urandom, 0, 1, 0);
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);

        // Flush while a full vector is being accepted: the vector is dropped.
        for (int i = 0; i < 4; i++) cycle4(1, $urandom, $urandom, 0, 0, 0);
        cycle4(0, 32'h0, 32'h0, 0, 1, 1);
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);
        // Flush in the middle of a partial vector.
        cycle4(1, $urandom, $urandom, 0, 0, 0);
        cycle4(1, $urandom, $urandom, 0, 0, 1);
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle4($urandom_range(0, 9) < 7, $urandom, $urandom,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 39) == 0);
        end
        cycle4(0, 32'h0, 32'h0, 0, 0, 0);

        // VLEN=1: back-to-back traffic yields one vector every two cycles.
        for (int i = 0; i < 12; i++) cycle1(1, $urandom, $urandom, 1);
        cycle1(0, 32'h0, 32'h0, 0);
        checkOutput("v1_vectors", 128'(validSeen), 128'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
